quiz_lock: RTL

//  8-way quiz-buzzer front end: synchronises and debounces eight raw push-buttons,

---
 rtl/quiz_pkg.sv | 36 +++
 rtl/key_debounce.sv | 62 ++++++
 rtl/quiz_lock.sv | 133 +++++++++++++
 3 files changed

// File: rtl/quiz_pkg.sv
// rtl/quiz_pkg.sv - shared state encoding, constants and winner pick for the quiz buzzer
//
// Purpose : definitions shared by quiz_lock and the downstream priority-encoder /
//           7-segment stage, so both agree on state codes and on "no winner".
// Contents: state_t       FSM state encoding (IDLE=0 .. TIMEOUT=4)
//           NUM_KEYS      number of contestant channels
//           NO_WINNER     winner value meaning "nobody" (display blank)
//           pick_highest  reduce a press vector to a one-hot of its highest set bit
package quiz_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_LOCKED  = 3'd2,
    ST_FOUL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  localparam int         NUM_KEYS  = 8;
  localparam logic [7:0] NO_WINNER = 8'h00;

  // Highest index wins so the latched winner matches the priority the
  // downstream encoder would apply to the same vector.
  function automatic logic [7:0] pick_highest(input logic [7:0] req);
    logic [7:0] r;
    r = NO_WINNER;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (req[i]) begin
        r    = NO_WINNER;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one button channel: 2-FF synchroniser, debounce counter, press pulse
//
// Purpose : turn one raw, bouncy, asynchronous button into a single-cycle press
//           pulse once a new high level has been held long enough.
// Ports   : clk      in  system clock
//           rst      in  asynchronous active-high reset
//           key_i    in  raw button level (asynchronous)
//           press_o  out 1-clk pulse on the accepted rising edge of the debounced level
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic press_o
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          stable_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter measures how long the synchronised input has disagreed with
  // the accepted level. Any agreement restarts the measurement, so a glitch
  // shorter than the threshold leaves no trace. It tops out at CNT_MAX and
  // is cleared by the toggle, so it never wraps.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= key_i;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
    end
  end

  // Rising edge of the accepted level only; releases produce nothing.
  assign press_o = stable_q & ~stable_prev_q;

endmodule

// File: rtl/quiz_lock.sv
// rtl/quiz_lock.sv - 8-way quiz buzzer front end: debounce, arm, first-press lock, foul, timeout
//
// Purpose : debounce eight contestant buttons, open an answer window on start,
//           latch the first contestant to press, flag presses before start
//           (foul) and windows that expire unanswered (timeout).
// Ports   : clk      in  1  system clock
//           rst      in  1  asynchronous active-high reset
//           key      in  8  raw buttons, active-high, asynchronous
//           start    in  1  1-clk host pulse: open the answer window
//           clear    in  1  1-clk host pulse: end the round, back to IDLE
//           winner   out 8  one-hot accepted/offending contestant, 0 = none
//           locked   out 1  valid answer latched
//           foul     out 1  press seen before start
//           timeout  out 1  window expired with no press
//           buzz     out 1  1-clk pulse on entry to LOCKED or FOUL
module quiz_lock
  import quiz_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WINDOW_CYCLES   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key,
  input  logic       start,
  input  logic       clear,
  output logic [7:0] winner,
  output logic       locked,
  output logic       foul,
  output logic       timeout,
  output logic       buzz
);

  localparam int            WW      = $clog2(WINDOW_CYCLES + 1);
  localparam logic [WW-1:0] WIN_MAX = WW'(WINDOW_CYCLES);
  localparam logic [WW-1:0] WIN_END = WW'(WINDOW_CYCLES - 1);

  logic [7:0]    press;
  logic [7:0]    press_pick;
  logic          any_press;
  logic          expire;

  state_t        state_q, state_d;
  logic [7:0]    winner_q, winner_d;
  logic          buzz_q, buzz_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk    (clk),
      .rst    (rst),
      .key_i  (key[g]),
      .press_o(press[g])
    );
  end

  assign press_pick = pick_highest(press);
  assign any_press  = |press;
  assign expire     = (win_cnt_q == WIN_END);

  // Priority inside each state: clear, then press, then start/expiry.
  // A press on the expiry cycle therefore still locks.
  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    buzz_d    = 1'b0;
    win_cnt_d = win_cnt_q;

    if (clear) begin
      state_d   = ST_IDLE;
      winner_d  = NO_WINNER;
      win_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_press) begin
            state_d  = ST_FOUL;
            winner_d = press_pick;
            buzz_d   = 1'b1;
          end else if (start) begin
            state_d   = ST_ARMED;
            win_cnt_d = '0;
          end
        end
        ST_ARMED: begin
          if (any_press) begin
            state_d  = ST_LOCKED;
            winner_d = press_pick;
            buzz_d   = 1'b1;
          end else if (expire) begin
            state_d  = ST_TIMEOUT;
            winner_d = NO_WINNER;
          end else if (win_cnt_q != WIN_MAX) begin
            win_cnt_d = win_cnt_q + WW'(1);
          end
        end
        ST_LOCKED, ST_FOUL: begin
          // Result held until clear.
        end
        ST_TIMEOUT: begin
          winner_d = NO_WINNER;
        end
        default: begin
          state_d  = ST_IDLE;
          winner_d = NO_WINNER;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      winner_q  <= NO_WINNER;
      buzz_q    <= 1'b0;
      win_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      buzz_q    <= buzz_d;
      win_cnt_q <= win_cnt_d;
    end
  end

  assign winner  = winner_q;
  assign locked  = (state_q == ST_LOCKED);
  assign foul    = (state_q == ST_FOUL);
  assign timeout = (state_q == ST_TIMEOUT);
  assign buzz    = buzz_q;

endmodule
